// File: rtl/rx_crc_strip_ctrl.sv
// ---------------------------------------------------------------------------
// rx_crc_strip_ctrl
//
// Controls the 64x8 CRC-holding FIFO in the USB receive data path. Every
// received data-packet byte is pushed into the FIFO. A byte is forwarded
// downstream only once HOLD newer bytes sit behind it, so the trailing CRC16
// never leaves the block. At end-of-packet the held CRC bytes are popped
// silently and a one-cycle pkt_done reports the packet status.
//
// Build option:
//   RX_CRC_CHECK_EN  defined   -> CRC16 engine present, crc_err includes a
//                                 CRC residue mismatch.
//                    undefined -> no CRC engine, crc_err = overflow | short.
//
// Ports:
//   clk, n_rst            clock, asynchronous active-low reset
//   sop                   1-cycle pulse, data packet starts (after PID)
//   byte_valid, byte_in   received byte stream
//   eop                   1-cycle pulse, packet ended
//   fifo_w_enable/w_data  FIFO push interface
//   fifo_r_enable/r_data  FIFO pop interface (r_data is the current head)
//   fifo_empty/full       FIFO status
//   out_valid/data/ready  downstream payload handshake
//   pkt_done              1-cycle pulse, packet finished
//   crc_ok, crc_err       packet status, valid with pkt_done
//   overflow              sticky byte-drop flag, cleared on sop
// ---------------------------------------------------------------------------
module rx_crc_strip_ctrl #(
    parameter int HOLD  = 2,
    parameter int DEPTH = 64,
    parameter int CNT_W = 7
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       sop,
    input  logic       byte_valid,
    input  logic [7:0] byte_in,
    input  logic       eop,
    output logic       fifo_w_enable,
    output logic [7:0] fifo_w_data,
    output logic       fifo_r_enable,
    input  logic [7:0] fifo_r_data,
    input  logic       fifo_empty,
    input  logic       fifo_full,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready,
    output logic       pkt_done,
    output logic       crc_ok,
    output logic       crc_err,
    output logic       overflow
);

    typedef enum logic [2:0] {IDLE, STREAM, DRAIN, FLUSH, DONE} state_t;

    localparam logic [CNT_W-1:0] HOLD_C  = CNT_W'(HOLD);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] SAT_C   = CNT_W'(DEPTH + 1);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;       // FIFO occupancy mirror
    logic [CNT_W-1:0] byte_cnt_q;  // received bytes, saturating
    logic             overflow_q;

    logic push, pop, drop, start, fwd, full;

`ifdef RX_CRC_CHECK_EN
    logic [15:0] crc_q;

    // USB CRC16: reflected polynomial, LSB of the byte first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc,
                                               input logic [7:0]  data);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) c = (c >> 1) ^ 16'hA001;
            else                c = c >> 1;
        end
        return c;
    endfunction
`endif

    // Treat our own count as authoritative too, so cnt can never pass DEPTH.
    assign full = fifo_full | (cnt_q == DEPTH_C);

    // ---------------- next state / outputs ----------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves a value unassigned, which would infer a latch.
        state_d  = state_q;
        push     = 1'b0;
        pop      = 1'b0;
        drop     = 1'b0;
        start    = 1'b0;
        fwd      = 1'b0;
        pkt_done = 1'b0;
        crc_err  = 1'b0;
        crc_ok   = 1'b0;

        case (state_q)
            IDLE: begin
                if (sop) begin
                    start   = 1'b1;
                    state_d = STREAM;
                end
            end

            STREAM: begin
                fwd = (cnt_q > HOLD_C);
                pop = fwd & out_ready & ~fifo_empty;
                if (sop) begin
                    // Abort: the partial packet is discarded without status.
                    start   = 1'b1;
                    state_d = FLUSH;
                end else begin
                    push = byte_valid & ~full;
                    drop = byte_valid & full;
                    if (eop) state_d = DRAIN;
                end
            end

            DRAIN: begin
                if (cnt_q > HOLD_C) begin
                    fwd = 1'b1;
                    pop = out_ready & ~fifo_empty;
                end else begin
                    // Remaining bytes are the CRC: pop them unseen.
                    pop = (cnt_q != '0) & ~fifo_empty;
                    if (cnt_q <= ONE_C) state_d = DONE;
                end
            end

            FLUSH: begin
                pop = (cnt_q != '0) & ~fifo_empty;
                if (cnt_q <= ONE_C) state_d = STREAM;
            end

            DONE: begin
                pkt_done = 1'b1;
                crc_err  = overflow_q | (byte_cnt_q < HOLD_C);
`ifdef RX_CRC_CHECK_EN
                crc_err  = crc_err | (crc_q != 16'hB001);
`endif
                crc_ok   = ~crc_err;
                state_d  = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    assign fifo_w_enable = push;
    assign fifo_w_data   = push ? byte_in : 8'h00;
    assign fifo_r_enable = pop;
    assign out_valid     = fwd;
    assign out_data      = fwd ? fifo_r_data : 8'h00;
    assign overflow      = overflow_q;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge n_rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block order.
        if (!n_rst) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q      <= '0;
            byte_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + ONE_C;
                2'b01:   cnt_q <= cnt_q - ONE_C;
                default: cnt_q <= cnt_q;
            endcase

            if (start) begin
                byte_cnt_q <= '0;
                overflow_q <= 1'b0;
            end else begin
                if ((state_q == STREAM) && byte_valid && (byte_cnt_q != SAT_C))
                    byte_cnt_q <= byte_cnt_q + ONE_C;
                if (drop) overflow_q <= 1'b1;
            end
        end
    end

`ifdef RX_CRC_CHECK_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)     crc_q <= 16'hFFFF;
        else if (start) crc_q <= 16'hFFFF;
        else if (push)  crc_q <= crc16_byte(crc_q, byte_in);
    end
`endif

endmodule

// File: tb/tb_rx_crc_strip_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rx_crc_strip_ctrl
//
// Directed bench for rx_crc_strip_ctrl with a behavioural 64x8 FIFO attached.
// Inputs change 1 time unit after the rising edge; a monitor samples DUT
// outputs on the falling edge.
// ---------------------------------------------------------------------------
module tb_rx_crc_strip_ctrl;

    localparam int HOLD  = 2;
    localparam int DEPTH = 64;
    localparam int CNT_W = 7;

`ifdef RX_CRC_CHECK_EN
    localparam logic CRC_EN = 1'b1;
`else
    localparam logic CRC_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       sop = 1'b0, byte_valid = 1'b0, eop = 1'b0, out_ready = 1'b0;
    logic [7:0] byte_in = 8'h00;

    logic       fifo_w_enable, fifo_r_enable, fifo_empty, fifo_full;
    logic [7:0] fifo_w_data, fifo_r_data;
    logic       out_valid, pkt_done, crc_ok, crc_err, overflow;
    logic [7:0] out_data;

    always #5 clk = ~clk;

    rx_crc_strip_ctrl #(.HOLD(HOLD), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .n_rst(n_rst),
        .sop(sop), .byte_valid(byte_valid), .byte_in(byte_in), .eop(eop),
        .fifo_w_enable(fifo_w_enable), .fifo_w_data(fifo_w_data),
        .fifo_r_enable(fifo_r_enable), .fifo_r_data(fifo_r_data),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .pkt_done(pkt_done), .crc_ok(crc_ok), .crc_err(crc_err),
        .overflow(overflow)
    );

    // ---------------- behavioural FIFO ----------------
    logic [7:0] mem [DEPTH];
    int wr_ptr, rd_ptr, fcount;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= 0;
            rd_ptr <= 0;
            fcount <= 0;
        end else begin
            if (fifo_w_enable) begin
                mem[wr_ptr] <= fifo_w_data;
                wr_ptr      <= (wr_ptr + 1) % DEPTH;
            end
            if (fifo_r_enable) rd_ptr <= (rd_ptr + 1) % DEPTH;
            fcount <= fcount + int'(fifo_w_enable) - int'(fifo_r_enable);
        end
    end

    assign fifo_r_data = mem[rd_ptr];
    assign fifo_empty  = (fcount == 0);
    assign fifo_full   = (fcount == DEPTH);

    // ---------------- monitor ----------------
    logic [7:0] fwd_q [$];
    int   done_cnt = 0;
    int   done_fcount = -1;
    int   rise_cnt = 99;
    logic last_ok = 1'b0, last_err = 1'b0;
    logic prev_ov = 1'b0;
    logic bad_pop = 1'b0, bad_push = 1'b0;

    always @(negedge clk) begin
        if (n_rst) begin
            if (out_valid && out_ready) fwd_q.push_back(out_data);
            if (out_valid && !prev_ov && rise_cnt == 99) rise_cnt = fcount;
            prev_ov = out_valid;
            if (pkt_done) begin
                done_cnt++;
                done_fcount = fcount;
                last_ok  = crc_ok;
                last_err = crc_err;
            end
            if (fifo_r_enable && fifo_empty) bad_pop = 1'b1;
            if (fifo_w_enable && fifo_full)  bad_push = 1'b1;
        end else begin
            prev_ov = 1'b0;
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_sop();
        sop = 1'b1; step(); sop = 1'b0;
    endtask

    task automatic pulse_eop();
        eop = 1'b1; step(); eop = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_valid = 1'b1; byte_in = b; step();
        byte_valid = 1'b0; byte_in = 8'h00;
    endtask

    // "123456789" followed by its USB CRC16 (C8 B4); last byte replaceable.
    task automatic send_body(input logic [7:0] last);
        logic [7:0] body [11];
        body = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38,
                 8'h39, 8'hC8, 8'hB4};
        body[10] = last;
        for (int i = 0; i < 11; i++) send_byte(body[i]);
    endtask

    task automatic send_pkt(input logic [7:0] last);
        pulse_sop();
        send_body(last);
        pulse_eop();
    endtask

    // Bounded wait for one pkt_done pulse; also confirms it lasted one cycle.
    task automatic wait_pkt(input string tag, input int prev);
        int n;
        n = 0;
        while (done_cnt == prev && n < 300) begin
            step();
            n++;
        end
        step();
        step();
        check({tag, "_done_pulses"}, done_cnt - prev, 1);
    endtask

    task automatic check_payload(input string tag);
        check({tag, "_fwd_count"}, fwd_q.size(), 9);
        for (int i = 0; i < 9; i++)
            check({tag, "_fwd_byte"}, (i < fwd_q.size()) ? fwd_q[i] : 8'hXX,
                  8'h31 + 8'(i));
    endtask

    // ---------------- test sequence ----------------
    int d0;

    initial begin
        // Reset state
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_w_enable",  fifo_w_enable, 0);
        check("rst_r_enable",  fifo_r_enable, 0);
        check("rst_pkt_done",  pkt_done, 0);
        check("rst_crc_ok",    crc_ok, 0);
        check("rst_crc_err",   crc_err, 0);
        check("rst_overflow",  overflow, 0);
        step();
        n_rst = 1'b1;
        step();

        // 1: good packet, downstream always ready
        out_ready = 1'b1;
        fwd_q.delete();
        d0 = done_cnt;
        send_pkt(8'hB4);
        wait_pkt("good", d0);
        check_payload("good");
        check("good_crc_ok",  last_ok, 1);
        check("good_crc_err", last_err, 0);

        // 2: corrupted CRC byte
        fwd_q.delete();
        d0 = done_cnt;
        send_pkt(8'hB5);
        wait_pkt("bad", d0);
        check_payload("bad");
        check("bad_crc_ok",  last_ok, !CRC_EN);
        check("bad_crc_err", last_err, CRC_EN);

        // 3: downstream stalled for whole packet, then released
        out_ready = 1'b0;
        fwd_q.delete();
        rise_cnt = 99;
        d0 = done_cnt;
        send_pkt(8'hB4);
        check("stall_no_fwd", fwd_q.size(), 0);
        check("stall_rise_cnt", rise_cnt, HOLD + 1);
        check("stall_fifo_cnt", fcount, 11);
        out_ready = 1'b1;
        wait_pkt("stall", d0);
        check_payload("stall");
        check("stall_cnt_at_done", done_fcount, 0);
        check("stall_crc_ok", last_ok, 1);

        // 4: 66 bytes into a stalled FIFO -> 2 dropped
        out_ready = 1'b0;
        fwd_q.delete();
        d0 = done_cnt;
        pulse_sop();
        for (int i = 0; i < 66; i++) send_byte(8'(i));
        check("ovf_flag", overflow, 1);
        check("ovf_fifo_cnt", fcount, DEPTH);
        pulse_eop();
        out_ready = 1'b1;
        wait_pkt("ovf", d0);
        check("ovf_fwd_count", fwd_q.size(), DEPTH - HOLD);
        check("ovf_fwd_first", (fwd_q.size() > 0) ? fwd_q[0] : 8'hXX, 8'h00);
        check("ovf_fwd_last",
              (fwd_q.size() == DEPTH - HOLD) ? fwd_q[DEPTH-HOLD-1] : 8'hXX,
              8'(DEPTH - HOLD - 1));
        check("ovf_crc_err", last_err, 1);
        check("ovf_crc_ok",  last_ok, 0);

        // 5a: one-byte packet
        fwd_q.delete();
        d0 = done_cnt;
        pulse_sop();
        check("sop_clears_ovf", overflow, 0);
        send_byte(8'h5A);
        pulse_eop();
        wait_pkt("short", d0);
        check("short_fwd_count", fwd_q.size(), 0);
        check("short_crc_err", last_err, 1);
        check("short_crc_ok",  last_ok, 0);

        // 5b: abort by second sop, FIFO flushed, new packet streams
        out_ready = 1'b0;
        fwd_q.delete();
        d0 = done_cnt;
        pulse_sop();
        for (int i = 0; i < 4; i++) send_byte(8'hA0 + 8'(i));
        check("abort_fifo_cnt", fcount, 4);
        pulse_sop();
        for (int i = 0; i < 8; i++) step();
        check("flush_fifo_empty", fcount, 0);
        check("flush_no_done", done_cnt - d0, 0);
        check("flush_no_fwd", fwd_q.size(), 0);
        out_ready = 1'b1;
        send_body(8'hB4);
        pulse_eop();
        wait_pkt("after_flush", d0);
        check_payload("after_flush");
        check("after_flush_crc_ok", last_ok, 1);

        // 6: asynchronous reset mid-STREAM with 5 bytes held
        out_ready = 1'b0;
        fwd_q.delete();
        pulse_sop();
        for (int i = 0; i < 5; i++) send_byte(8'h10 + 8'(i));
        check("prerst_fifo_cnt", fcount, 5);
        check("prerst_out_valid", out_valid, 1);
        #2;
        n_rst = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_data",  out_data, 0);
        check("mid_rst_r_enable",  fifo_r_enable, 0);
        check("mid_rst_w_enable",  fifo_w_enable, 0);
        check("mid_rst_pkt_done",  pkt_done, 0);
        check("mid_rst_overflow",  overflow, 0);
        step();
        step();
        n_rst = 1'b1;
        step();
        byte_valid = 1'b1;
        byte_in    = 8'h77;
        #3;
        check("idle_ignores_byte", fifo_w_enable, 0);
        step();
        byte_valid = 1'b0;
        out_ready  = 1'b1;
        fwd_q.delete();
        d0 = done_cnt;
        send_pkt(8'hB4);
        wait_pkt("post_rst", d0);
        check_payload("post_rst");
        check("post_rst_crc_ok", last_ok, 1);

        check("never_pop_empty", bad_pop, 0);
        check("never_push_full", bad_push, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
